// File: rtl/alu_issue.sv
// Issue stage for the 4-bit ALU: accepts instructions, holds a small register file,
// drives operands into the ALU and writes the {ah,al} result back after ALU_LAT edges.
module alu_issue #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned NREGS   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [12:0]                in_instr,
  output logic [2:0]                 alu_opcode,
  output logic [3:0]                 alu_b,
  output logic [3:0]                 alu_c,
  input  logic [3:0]                 alu_ah,
  input  logic [3:0]                 alu_al,
  output logic                       done,
  output logic                       busy,
  input  logic [$clog2(NREGS)-1:0]   dbg_sel,
  output logic [3:0]                 dbg_data
);

  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned DW = 4;
  localparam int unsigned OW = 3;
  localparam int unsigned CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   op_q, op_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   c_q, c_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   rf_q [NREGS];
  logic [DW-1:0]   rf_d [NREGS];

  // Instruction field decode; rc and imm overlap, meaning depends on ld.
  logic            f_ld;
  logic [OW-1:0]   f_op;
  logic [RW-1:0]   f_rd, f_rb, f_rc, wb_hi;
  logic [DW-1:0]   f_imm;

  assign f_ld  = in_instr[12];
  assign f_op  = in_instr[11:9];
  assign f_rd  = RW'(in_instr[8:7]);
  assign f_rb  = RW'(in_instr[6:5]);
  assign f_rc  = RW'(in_instr[4:3]);
  assign f_imm = in_instr[3:0];
  assign wb_hi = rd_q + RW'(1);

  assign in_ready   = (state_q == S_IDLE);
  assign alu_opcode = op_q;
  assign alu_b      = b_q;
  assign alu_c      = c_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign dbg_data   = rf_q[dbg_sel];

  // Next-state: loads write the file immediately, ALU ops latch operands then wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    c_d     = c_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rf_d    = rf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (f_ld) begin
            rf_d[f_rd] = f_imm;
          end else begin
            state_d = S_EXEC;
            op_d    = f_op;
            b_d     = rf_q[f_rb];
            c_d     = rf_q[f_rc];
            rd_d    = f_rd;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == CW'(ALU_LAT)) begin
          rf_d[rd_q]  = alu_al;
          rf_d[wb_hi] = alu_ah;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      c_q     <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rf_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      c_q     <= c_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed instructions, scoreboard of expected ALU operands checked
// whenever done pulses, plus direct register-file and handshake checks.
module tb_alu_issue;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_instr;
  logic [2:0]  alu_opcode;
  logic [3:0]  alu_b, alu_c;
  logic [3:0]  alu_ah, alu_al;
  logic        done, busy;
  logic [1:0]  dbg_sel;
  logic [3:0]  dbg_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] b;
    logic [3:0] c;
  } exp_t;
  exp_t sbq[$];

  alu_issue #(.ALU_LAT(1), .NREGS(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_opcode (alu_opcode),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .alu_ah     (alu_ah),
    .alu_al     (alu_al),
    .done       (done),
    .busy       (busy),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ALU stand-in: {ah,al} = {c,b} one edge later.
  always_ff @(posedge clock) begin
    alu_ah <= alu_c;
    alu_al <= alu_b;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] ld_w(input logic [1:0] rd, input logic [3:0] imm);
    return {1'b1, 3'b000, rd, 3'b000, imm};
  endfunction

  function automatic logic [12:0] op_w(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rb, input logic [1:0] rc);
    return {1'b0, op, rd, rb, rc, 3'b000};
  endfunction

  task automatic chk_reg(input logic [1:0] r, input logic [3:0] v, input string name);
    dbg_sel = r;
    #1;
    check(name, {4'h0, dbg_data}, {4'h0, v});
  endtask

  // Present a word and return #1 after the edge that accepts it; valid stays high.
  task automatic issue(input logic [12:0] w, output int waited);
    logic rdy;
    bit   got;
    in_valid = 1'b1;
    in_instr = w;
    waited   = 0;
    got      = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!got) begin
        rdy = in_ready;
        @(posedge clock);
        #1;
        if (rdy) got = 1'b1;
        else waited++;
      end
    end
    if (!got) check("accept_timeout", 8'(got), 8'd1);
  endtask

  task automatic chk_idle_zero(input string tag);
    check({tag, "_ready"},  8'(in_ready),   8'd1);
    check({tag, "_busy"},   8'(busy),       8'd0);
    check({tag, "_done"},   8'(done),       8'd0);
    check({tag, "_opcode"}, 8'(alu_opcode), 8'd0);
    check({tag, "_b"},      8'(alu_b),      8'd0);
    check({tag, "_c"},      8'(alu_c),      8'd0);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected ALU issue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          check("spurious_done", 8'(done), 8'd0);
        end else begin
          e = sbq.pop_front();
          check("sb_opcode", 8'(alu_opcode), 8'(e.op));
          check("sb_b",      8'(alu_b),      8'(e.b));
          check("sb_c",      8'(alu_c),      8'(e.c));
        end
      end
    end
  end

  initial begin
    int w;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    dbg_sel  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk_idle_zero("por");
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Back-to-back loads
    issue(ld_w(2'd0, 4'hA), w);
    check("ld0_wait", 8'(w), 8'd0);
    issue(ld_w(2'd1, 4'h2), w);
    check("ld1_wait", 8'(w), 8'd0);
    in_valid = 1'b0;
    check("ld_no_done", 8'(done), 8'd0);
    check("ld_opcode",  8'(alu_opcode), 8'd0);
    chk_reg(2'd0, 4'hA, "ld_r0");
    chk_reg(2'd1, 4'h2, "ld_r1");

    // op 011 rd=2 rb=0 rc=1
    sbq.push_back('{op: 3'b011, b: 4'hA, c: 4'h2});
    issue(op_w(3'b011, 2'd2, 2'd0, 2'd1), w);
    in_valid = 1'b0;
    check("op1_wait",   8'(w),          8'd0);
    check("op1_busy",   8'(busy),       8'd1);
    check("op1_ready",  8'(in_ready),   8'd0);
    check("op1_opcode", 8'(alu_opcode), 8'd3);
    check("op1_b",      8'(alu_b),      8'hA);
    check("op1_c",      8'(alu_c),      8'h2);
    @(posedge clock); #1;
    check("op1_a1_ready", 8'(in_ready), 8'd0);
    check("op1_a1_done",  8'(done),     8'd0);
    @(posedge clock); #1;
    check("op1_a2_done",  8'(done),     8'd1);
    check("op1_a2_ready", 8'(in_ready), 8'd1);
    check("op1_a2_busy",  8'(busy),     8'd0);
    chk_reg(2'd2, 4'hA, "op1_r2");
    chk_reg(2'd3, 4'h2, "op1_r3");
    @(posedge clock); #1;
    check("op1_done_once", 8'(done), 8'd0);

    // Load leaves ALU outputs untouched
    issue(ld_w(2'd1, 4'h5), w);
    in_valid = 1'b0;
    check("ld_keep_op", 8'(alu_opcode), 8'd3);
    check("ld_keep_c",  8'(alu_c),      8'h2);

    // rd=3 wraps high nibble into R0
    sbq.push_back('{op: 3'b011, b: 4'hA, c: 4'h5});
    issue(op_w(3'b011, 2'd3, 2'd0, 2'd1), w);
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("op2_done", 8'(done), 8'd1);
    chk_reg(2'd3, 4'hA, "op2_r3");
    chk_reg(2'd0, 4'h5, "op2_r0_wrap");
    chk_reg(2'd1, 4'h5, "op2_r1_keep");
    chk_reg(2'd2, 4'hA, "op2_r2_keep");

    // Held valid during EXEC: second word waits two cycles, accepted once
    sbq.push_back('{op: 3'b101, b: 4'hA, c: 4'hA});
    sbq.push_back('{op: 3'b110, b: 4'h5, c: 4'hA});
    issue(op_w(3'b101, 2'd1, 2'd2, 2'd3), w);
    issue(op_w(3'b110, 2'd0, 2'd0, 2'd1), w);
    in_valid = 1'b0;
    check("held_wait",   8'(w),          8'd2);
    check("held_opcode", 8'(alu_opcode), 8'd6);
    check("held_b",      8'(alu_b),      8'h5);
    check("held_c",      8'(alu_c),      8'hA);
    repeat (2) @(posedge clock);
    #1;
    check("held_done", 8'(done), 8'd1);
    chk_reg(2'd0, 4'h5, "held_r0");
    chk_reg(2'd1, 4'hA, "held_r1");
    chk_reg(2'd2, 4'hA, "held_r2");
    repeat (3) @(posedge clock);
    #1;
    check("held_idle_busy", 8'(busy), 8'd0);

    // Reset in the middle of an ALU op: no write-back, no done
    issue(op_w(3'b111, 2'd2, 2'd0, 2'd1), w);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk_idle_zero("mid_rst");
    for (int r = 0; r < 4; r++) chk_reg(2'(r), 4'h0, "mid_rst_reg");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk_idle_zero("post_rst");
    repeat (3) @(posedge clock);
    #1;
    check("post_rst_done", 8'(done), 8'd0);
    chk_reg(2'd2, 4'h0, "post_rst_r2");

    check("sb_empty", 8'(sbq.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
